// File: rtl/pcm_mixer.sv
// pcm_mixer: N-channel PCM mixer for the tone generator, RDS and external audio paths.
// Each sample strobe captures all channel inputs. The captured samples are then
// accumulated gain-weighted, one channel per clock, through a single multiplier.
// The sum is rescaled so that a gain of 2^(GAIN_W-1) is unity. It is then
// saturated and presented with a one-cycle valid pulse.
module pcm_mixer #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 16,
    parameter int GAIN_W   = 8,
    parameter int OUT_W    = 16
) (
    input  logic                         clk_25m,
    input  logic                         rst_n,
    input  logic                         sample_strobe,
    input  logic [CHANNELS*DATA_W-1:0]   pcm_in,
    input  logic [CHANNELS*GAIN_W-1:0]   gain,
    input  logic [CHANNELS-1:0]          mute,
    output logic signed [OUT_W-1:0]      pcm_out,
    output logic                         pcm_valid,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun
);

    // Product is signed sample times zero-extended gain. The accumulator adds
    // headroom for summing all channels, so it can never wrap.
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(CHANNELS);
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // Saturation compare width is wide enough for both the scaled sum and the output range.
    localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX  = EXT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN  = EXT_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state_r;
    logic signed [DATA_W-1:0]  pcm_snap_r  [CHANNELS];
    logic [GAIN_W-1:0]         gain_snap_r [CHANNELS];
    logic [CHANNELS-1:0]       mute_snap_r;
    logic [IDX_W-1:0]          idx_r;
    logic signed [ACC_W-1:0]   acc_r;

    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   term_s;
    logic signed [EXT_W-1:0]   scaled_s;
    logic signed [OUT_W-1:0]   sat_s;
    logic                      sat_hit_s;

    // Weighted term for the current channel, and the rescaled, saturated frame result.
    always_comb begin
        prod_s    = $signed(PROD_W'(pcm_snap_r[idx_r])) *
                    $signed(PROD_W'({1'b0, gain_snap_r[idx_r]}));
        term_s    = '0;
        if (mute_snap_r[idx_r]) begin
            term_s = '0;
        end else begin
            term_s = ACC_W'(prod_s);
        end
        // The arithmetic shift floors toward minus infinity.
        scaled_s  = EXT_W'(acc_r >>> (GAIN_W - 1));
        sat_s     = '0;
        sat_hit_s = 1'b0;
        if (scaled_s > SAT_MAX) begin
            sat_s     = SAT_MAX[OUT_W-1:0];
            sat_hit_s = 1'b1;
        end else if (scaled_s < SAT_MIN) begin
            sat_s     = SAT_MIN[OUT_W-1:0];
            sat_hit_s = 1'b1;
        end else begin
            sat_s     = scaled_s[OUT_W-1:0];
            sat_hit_s = 1'b0;
        end
    end

    // Frame sequencer: snapshot on strobe, accumulate one channel per clock, then emit.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            acc_r       <= '0;
            mute_snap_r <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                pcm_snap_r[k]  <= '0;
                gain_snap_r[k] <= '0;
            end
            pcm_out     <= '0;
            pcm_valid   <= 1'b0;
            busy        <= 1'b0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            clip      <= 1'b0;
            // A strobe during a frame is dropped. This flag stays set until reset.
            if (sample_strobe && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (sample_strobe) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            pcm_snap_r[k]  <= pcm_in[k*DATA_W +: DATA_W];
                            gain_snap_r[k] <= gain[k*GAIN_W +: GAIN_W];
                        end
                        mute_snap_r <= mute;
                        acc_r       <= '0;
                        idx_r       <= '0;
                        busy        <= 1'b1;
                        state_r     <= ACC;
                    end
                end
                ACC: begin
                    acc_r <= acc_r + term_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= '0;
                        state_r <= OUT;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                OUT: begin
                    pcm_out   <= sat_s;
                    pcm_valid <= 1'b1;
                    clip      <= sat_hit_s;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    idx_r   <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_mixer.sv
// tb_pcm_mixer: directed and randomized frames for pcm_mixer (4 channels, unity gain 128).
// Expected results come from an arithmetic reference: sum, floor-divide, clamp.
module tb_pcm_mixer;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int GW = 8;
    localparam int OW = 16;

    logic                  clk_25m = 1'b0;
    logic                  rst_n;
    logic                  sample_strobe;
    logic [CH*DW-1:0]      pcm_in;
    logic [CH*GW-1:0]      gain;
    logic [CH-1:0]         mute;
    logic signed [OW-1:0]  pcm_out;
    logic                  pcm_valid;
    logic                  busy;
    logic                  clip;
    logic                  overrun;

    int checks   = 0;
    int failures = 0;

    // Reference copy of the channel settings for the next frame.
    int smp [CH];
    int gn  [CH];
    bit mt  [CH];

    pcm_mixer #(.CHANNELS(CH), .DATA_W(DW), .GAIN_W(GW), .OUT_W(OW)) dut (
        .clk_25m       (clk_25m),
        .rst_n         (rst_n),
        .sample_strobe (sample_strobe),
        .pcm_in        (pcm_in),
        .gain          (gain),
        .mute          (mute),
        .pcm_out       (pcm_out),
        .pcm_valid     (pcm_valid),
        .busy          (busy),
        .clip          (clip),
        .overrun       (overrun)
    );

    // 25 MHz clock
    always #20 clk_25m = ~clk_25m;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25m);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < CH; k++) begin
            smp[k] = 0;
            gn[k]  = 0;
            mt[k]  = 1'b0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < CH; k++) begin
            pcm_in[k*DW +: DW] = DW'(smp[k]);
            gain[k*GW +: GW]   = GW'(gn[k]);
            mute[k]            = mt[k];
        end
    endtask

    // Mix result: weighted sum, divided by unity gain with floor rounding, then clamped.
    function automatic longint model_out(output bit clp);
        longint sum;
        longint q;
        sum = 0;
        for (int k = 0; k < CH; k++) begin
            if (!mt[k]) sum += longint'(smp[k]) * longint'(gn[k]);
        end
        q = sum / 128;
        if ((sum % 128 != 0) && (sum < 0)) q = q - 1;
        clp = 1'b0;
        if (q > 32767) begin
            q = 32767;
            clp = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            clp = 1'b1;
        end
        return q;
    endfunction

    // Strobe one frame and check latency and result. Returns in the pcm_valid cycle.
    task automatic run_frame(input string tag, input bit scramble);
        longint e;
        bit     ec;
        int     n;
        e = model_out(ec);
        drive();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check({tag, ".busy"}, longint'(busy), 1);
        if (scramble) begin
            pcm_in = {$urandom, $urandom};
            gain   = $urandom;
            mute   = 4'($urandom);
        end
        n = 0;
        while (!pcm_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, longint'(n), 5);
        check({tag, ".pcm_out"}, longint'(pcm_out), e);
        check({tag, ".clip"}, longint'(clip), longint'(ec));
        check({tag, ".busy_end"}, longint'(busy), 0);
    endtask

    initial begin
        int nv;
        rst_n         = 1'b0;
        sample_strobe = 1'b0;
        pcm_in        = '0;
        gain          = '0;
        mute          = '0;
        clear_model();

        // 1. Reset holds all outputs low while inputs toggle
        for (int i = 0; i < 6; i++) begin
            pcm_in        = {$urandom, $urandom};
            gain          = $urandom;
            mute          = 4'($urandom);
            sample_strobe = 1'($urandom);
            tick();
        end
        check("rst.pcm_out", longint'(pcm_out), 0);
        check("rst.valid", longint'(pcm_valid), 0);
        check("rst.busy", longint'(busy), 0);
        check("rst.clip", longint'(clip), 0);
        check("rst.overrun", longint'(overrun), 0);
        sample_strobe = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        run_frame("zero", 1'b0);
        tick();
        check("zero.pulse_end", longint'(pcm_valid), 0);
        check("zero.hold", longint'(pcm_out), 0);

        // 2. Unity gain and floor rounding
        clear_model();
        smp[0] = 1000; gn[0] = 128;
        run_frame("unity", 1'b0);
        check("unity.const", longint'(pcm_out), 1000);
        tick();
        check("unity.hold", longint'(pcm_out), 1000);
        smp[0] = -3; gn[0] = 64;
        run_frame("floor", 1'b0);
        check("floor.const", longint'(pcm_out), -2);

        // 3. Saturation both ways, and a large in-range sum
        clear_model();
        for (int k = 0; k < CH; k++) begin smp[k] = 20000; gn[k] = 128; end
        run_frame("sat_pos", 1'b0);
        check("sat_pos.const", longint'(pcm_out), 32767);
        for (int k = 0; k < CH; k++) smp[k] = -20000;
        run_frame("sat_neg", 1'b0);
        check("sat_neg.const", longint'(clip), 1);
        for (int k = 0; k < CH; k++) smp[k] = (k < 3) ? 10000 : 0;
        run_frame("near_full", 1'b0);
        check("near_full.const", longint'(pcm_out), 30000);

        // 4. Mute, with inputs scrambled right after the strobe
        clear_model();
        smp[0] = 1000; smp[1] = 5000; smp[2] = -250; smp[3] = 0;
        for (int k = 0; k < CH; k++) gn[k] = 128;
        mt[1] = 1'b1;
        tick();
        run_frame("mute_snap", 1'b1);
        check("mute_snap.const", longint'(pcm_out), 750);

        // Randomized frames, alternating back-to-back and spaced strobes
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < CH; k++) begin
                smp[k] = int'($urandom_range(65535, 0)) - 32768;
                gn[k]  = int'($urandom_range(255, 0));
                mt[k]  = 1'($urandom_range(1, 0));
            end
            if (i % 3 == 0) tick();
            run_frame("rand", 1'b0);
        end

        // 5. Overrun: a second strobe at E2 is dropped, and the flag is sticky
        tick();
        check("ovr.before", longint'(overrun), 0);
        clear_model();
        smp[1] = 3000; gn[1] = 128;
        drive();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        check("ovr.set", longint'(overrun), 1);
        tick();
        tick();
        tick();
        check("ovr.valid", longint'(pcm_valid), 1);
        check("ovr.pcm_out", longint'(pcm_out), 3000);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pcm_valid) nv++;
        end
        check("ovr.no_second", longint'(nv), 0);
        check("ovr.sticky", longint'(overrun), 1);

        // Back-to-back: a strobe in the pcm_valid cycle is accepted
        clear_model();
        smp[2] = -700; gn[2] = 200;
        run_frame("b2b_a", 1'b0);
        smp[3] = 12345; gn[3] = 255; smp[2] = 0;
        run_frame("b2b_b", 1'b0);

        // 6. Reset mid-frame discards the partial frame
        clear_model();
        smp[0] = 1234; gn[0] = 128;
        drive();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst.busy", longint'(busy), 0);
        check("midrst.pcm_out", longint'(pcm_out), 0);
        check("midrst.valid", longint'(pcm_valid), 0);
        check("midrst.overrun", longint'(overrun), 0);
        tick();
        tick();
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pcm_valid) nv++;
        end
        check("midrst.no_valid", longint'(nv), 0);
        run_frame("post_rst", 1'b0);
        check("post_rst.const", longint'(pcm_out), 1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
